// File: rtl/db9md_poll_sequencer.sv
// Poll sequencer for two Mega Drive pads sharing one set of DB9 data lines:
// drives port/pad select, samples each phase and commits one word per player per pass.
module db9md_poll_sequencer #(
  parameter int PHASE_CYC = 480,
  parameter int IDLE_CYC  = 96000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [5:0]  joy_in,
  output logic        joy_split,
  output logic        joy_mdsel,
  output logic [15:0] joystick1,
  output logic [15:0] joystick2,
  output logic        present1,
  output logic        present2,
  output logic        six1,
  output logic        six2,
  output logic        upd
);

  localparam int CNT_MAX = (IDLE_CYC > PHASE_CYC) ? IDLE_CYC : PHASE_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'(PHASE_CYC - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(IDLE_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_P1, S_P2} state_t;

  state_t           state, state_nxt;
  logic [2:0]       ph, ph_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             sample, commit;

  logic [5:0]  joy_p0, joy_p1;
  logic [5:0]  pins;
  logic [11:0] scr_word;
  logic        scr_present, scr_six;

  function automatic logic [15:0] frame_word(input logic [11:0] w,
                                             input logic present,
                                             input logic six);
    logic [15:0] r;
    r = {4'b0000, w};
    if (!present)
      r = '0;
    else if (!six)
      r[11:8] = 4'b0000;
    return r;
  endfunction

  // Stage p0/p1: two-flop synchronizer; idle pad lines are pulled high
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      joy_p0 <= '1;
      joy_p1 <= '1;
    end else begin
      joy_p0 <= joy_in;
      joy_p1 <= joy_p0;
    end
  end

  assign pins = ~joy_p1;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      ph    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      ph    <= ph_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ph_nxt    = ph;
    cnt_nxt   = cnt + CNT_W'(1);
    sample    = 1'b0;
    commit    = 1'b0;
    if (!enable) begin
      state_nxt = S_IDLE;
      ph_nxt    = '0;
      cnt_nxt   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cnt == IDLE_LAST) begin
            state_nxt = S_P1;
            ph_nxt    = '0;
            cnt_nxt   = '0;
          end
        end
        default: begin
          if (cnt == PHASE_LAST) begin
            sample  = 1'b1;
            cnt_nxt = '0;
            if (ph == 3'd7) begin
              commit    = 1'b1;
              ph_nxt    = '0;
              state_nxt = (state == S_P1) ? S_P2 : S_IDLE;
            end else begin
              ph_nxt = ph + 3'd1;
            end
          end
        end
      endcase
    end
  end

  // Scratch capture; the ph0 sample overwrites every field, which starts each frame clean
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      scr_word    <= '0;
      scr_present <= 1'b0;
      scr_six     <= 1'b0;
    end else if (!enable) begin
      scr_word    <= '0;
      scr_present <= 1'b0;
      scr_six     <= 1'b0;
    end else if (sample) begin
      case (ph)
        3'd0: begin
          scr_word    <= {6'b000000, pins[5], pins[4], pins[0], pins[1], pins[2], pins[3]};
          scr_present <= 1'b0;
          scr_six     <= 1'b0;
        end
        3'd1: begin
          scr_word[6] <= pins[4];
          scr_word[7] <= pins[5];
          scr_present <= pins[2] & pins[3];
        end
        3'd5: begin
          if (&pins[3:0])
            scr_six <= 1'b1;
        end
        3'd6: begin
          if (scr_six) begin
            scr_word[11] <= pins[0];
            scr_word[10] <= pins[1];
            scr_word[9]  <= pins[2];
            scr_word[8]  <= pins[3];
          end
        end
        default: ;
      endcase
    end
  end

  // Selects are registered from the next state so they switch on the phase-start edge
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      joy_split <= 1'b1;
      joy_mdsel <= 1'b1;
      joystick1 <= '0;
      joystick2 <= '0;
      present1  <= 1'b0;
      present2  <= 1'b0;
      six1      <= 1'b0;
      six2      <= 1'b0;
      upd       <= 1'b0;
    end else begin
      joy_split <= (state_nxt != S_P2);
      joy_mdsel <= (state_nxt == S_IDLE) || !ph_nxt[0];
      upd       <= 1'b0;
      if (!enable) begin
        joystick1 <= '0;
        joystick2 <= '0;
        present1  <= 1'b0;
        present2  <= 1'b0;
        six1      <= 1'b0;
        six2      <= 1'b0;
      end else if (commit) begin
        if (state == S_P1) begin
          joystick1 <= frame_word(scr_word, scr_present, scr_six);
          present1  <= scr_present;
          six1      <= scr_present & scr_six;
        end else begin
          joystick2 <= frame_word(scr_word, scr_present, scr_six);
          present2  <= scr_present;
          six2      <= scr_present & scr_six;
          upd       <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_db9md_poll_sequencer.sv
// Bench for db9md_poll_sequencer: bus-functional MD pads on both ports plus a
// pass-timeline model predicting every output on every cycle.
module tb_db9md_poll_sequencer;

  localparam int P = 8;
  localparam int I = 32;
  localparam int L = 16 * P + I;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b1;
  logic        enable = 1'b0;
  logic [5:0]  joy_in;
  logic        joy_split, joy_mdsel;
  logic [15:0] joystick1, joystick2;
  logic        present1, present2, six1, six2, upd;

  int checks   = 0;
  int failures = 0;

  // pad configuration: type 0 = unplugged, 3 = 3-button, 6 = 6-button
  int          type1 = 0, type2 = 0;
  logic [11:0] btn1 = '0, btn2 = '0;
  int          k1 = 0, k2 = 0, hi_cnt = 0;
  logic        mdsel_prev = 1'b1;

  // reference model state
  int          n = 0;
  int          mpos;
  logic [15:0] ej1 = '0, ej2 = '0;
  logic        ep1 = 1'b0, ep2 = 1'b0, es1 = 1'b0, es2 = 1'b0, eupd = 1'b0;
  int          st1 = 0, st2 = 0;
  logic [11:0] sb1 = '0, sb2 = '0;

  always #5 clk = ~clk;

  db9md_poll_sequencer #(.PHASE_CYC(P), .IDLE_CYC(I)) dut (
    .clk_sys   (clk),
    .reset_n   (rst_n),
    .enable    (enable),
    .joy_in    (joy_in),
    .joy_split (joy_split),
    .joy_mdsel (joy_mdsel),
    .joystick1 (joystick1),
    .joystick2 (joystick2),
    .present1  (present1),
    .present2  (present2),
    .six1      (six1),
    .six2      (six2),
    .upd       (upd)
  );

  // Pad pin levels (active-low) for a given select level and count of select falls
  function automatic logic [5:0] pad_out(input int typ, input logic [11:0] b,
                                         input int k, input logic sel);
    logic [5:0] a;
    if (typ == 0) return 6'h3F;
    a = '0;
    if (sel) begin
      if (typ == 6 && k == 3) a[3:0] = {b[8], b[9], b[10], b[11]};
      else                    a[3:0] = {b[0], b[1], b[2], b[3]};
      a[4] = b[4];
      a[5] = b[5];
    end else begin
      if (typ == 6 && k == 3)      a[3:0] = 4'hF;
      else if (typ == 6 && k == 4) a[3:0] = 4'h0;
      else                         a[3:0] = {2'b11, b[2], b[3]};
      a[4] = b[6];
      a[5] = b[7];
    end
    return ~a;
  endfunction

  assign joy_in = joy_split ? pad_out(type1, btn1, k1, joy_mdsel)
                            : pad_out(type2, btn2, k2, joy_mdsel);

  always @(negedge clk) begin
    if (mdsel_prev && !joy_mdsel) begin
      if (joy_split) k1 = k1 + 1;
      else           k2 = k2 + 1;
    end
    if (!joy_split) k1 = 0;
    else            k2 = 0;
    hi_cnt = joy_mdsel ? hi_cnt + 1 : 0;
    if (hi_cnt >= 16) begin
      k1 = 0;
      k2 = 0;
    end
    mdsel_prev = joy_mdsel;
  end

  function automatic logic [15:0] exp_word(input int typ, input logic [11:0] b);
    if (typ == 0) return 16'h0000;
    if (typ == 3) return {8'h00, b[7:0]};
    return {4'h0, b};
  endfunction

  // Timeline model: n counts enabled edges since reset/disable
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || !enable) begin
      n = 0;
      ej1 = '0; ej2 = '0; ep1 = 1'b0; ep2 = 1'b0;
      es1 = 1'b0; es2 = 1'b0; eupd = 1'b0;
    end else begin
      n = n + 1;
      mpos = n % L;
      eupd = 1'b0;
      if (mpos == I) begin
        st1 = type1;
        sb1 = btn1;
      end
      if (mpos == I + 8 * P) begin
        ej1 = exp_word(st1, sb1);
        ep1 = (st1 != 0);
        es1 = (st1 == 6);
        st2 = type2;
        sb2 = btn2;
      end
      if (mpos == 0) begin
        ej2 = exp_word(st2, sb2);
        ep2 = (st2 != 0);
        es2 = (st2 == 6);
        eupd = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    int   pos;
    logic em, esp;
    logic [38:0] act, expv;
    pos = n % L;
    esp = (pos < I + 8 * P);
    em  = (pos < I) || (((pos - I) / P) % 2 == 0);
    act  = {joy_split, joy_mdsel, upd, present1, six1, present2, six2, joystick1, joystick2};
    expv = {esp, em, eupd, ep1, es1, ep2, es2, ej1, ej2};
    checks = checks + 1;
    if (act !== expv) begin
      failures = failures + 1;
      $display("FAIL cycle_cmp t=%0t n=%0d actual=%h expected=%h", $time, n, act, expv);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic wait_pos(input int target);
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while ((n % L) != target && guard < 2 * L + 10);
    if ((n % L) != target) begin
      checks = checks + 1;
      failures = failures + 1;
      $display("FAIL wait_pos actual=%0d expected=%0d", n % L, target);
    end
  endtask

  task automatic count_while(input logic level, output int c);
    c = 0;
    do begin
      @(posedge clk);
      #1;
      c++;
    end while (joy_mdsel == level && c < 4 * L);
  endtask

  function automatic int rand_type();
    int r;
    r = $urandom_range(0, 2);
    return (r == 0) ? 0 : (r == 1) ? 3 : 6;
  endfunction

  function automatic logic [11:0] rand_btn();
    logic [11:0] b;
    b = 12'($urandom);
    if (b[3] && b[2]) b[2] = 1'b0;
    return b;
  endfunction

  initial begin
    int c;
    int u;
    #1 rst_n = 1'b0;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_split", joy_split, 1);
    check("rst_mdsel", joy_mdsel, 1);
    check("rst_words", {joystick1, joystick2}, 0);
    check("rst_flags", {upd, present1, present2, six1, six2}, 0);
    rst_n = 1'b1;
    count_while(1'b1, c);
    check("first_mdsel_fall", c, I + P);
    count_while(1'b0, c);
    check("mdsel_low_len", c, P);
    count_while(1'b1, c);
    check("mdsel_high_len", c, P);

    // no pads
    u = 0;
    repeat (2 * L) begin
      @(negedge clk);
      if (upd) u++;
    end
    check("upd_per_2_passes", u, 2);
    check("nopad_words", {joystick1, joystick2}, 0);
    check("nopad_present", {present1, present2}, 0);

    // 3-button pad on P1: A + Right
    wait_pos(2);
    type1 = 3;
    btn1  = 12'h041;
    wait_pos(I + 8 * P);
    check("p1_3btn_word", joystick1, 16'h0041);
    check("p1_3btn_flags", {present1, six1}, 2'b10);
    wait_pos(1);
    check("p2_unplugged", {joystick2, present2}, 0);

    // 6-button pad on P2: Up + Mode + Z, then release Z
    wait_pos(2);
    type2 = 6;
    btn2  = 12'h908;
    wait_pos(0);
    check("p2_6btn_word", joystick2, 16'h0908);
    check("p2_6btn_flags", {present2, six2, upd}, 3'b111);
    wait_pos(2);
    btn2 = 12'h108;
    wait_pos(0);
    check("p2_6btn_noz", joystick2, 16'h0108);

    // B pressed during the last clock of P1 ph0
    wait_pos(2);
    btn1 = 12'h000;
    wait_pos(I + P - 1);
    btn1 = 12'h010;
    wait_pos(I + 8 * P);
    check("late_b_same_frame", joystick1, 16'h0000);
    wait_pos(I + 8 * P);
    check("late_b_next_frame", joystick1, 16'h0010);

    // disable during P1 ph3
    wait_pos(I + 3 * P + 2);
    enable = 1'b0;
    @(posedge clk);
    #1;
    check("dis_selects", {joy_split, joy_mdsel}, 2'b11);
    check("dis_words", {joystick1, joystick2}, 0);
    check("dis_flags", {present1, present2, six1, six2, upd}, 0);
    repeat (5) @(negedge clk);
    enable = 1'b1;
    count_while(1'b1, c);
    check("reenable_mdsel_fall", c, I + P);

    // randomized pads and buttons, changed only early in IDLE
    repeat (10) begin
      wait_pos(2);
      type1 = rand_type();
      type2 = rand_type();
      btn1  = rand_btn();
      btn2  = rand_btn();
    end
    wait_pos(1);

    // reset mid-P2
    wait_pos(I + 8 * P + 3 * P + 3);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_selects", {joy_split, joy_mdsel}, 2'b11);
    check("midrst_outputs", {joystick1, joystick2, upd, present1, present2, six1, six2}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    count_while(1'b1, c);
    check("midrst_first_fall", c, I + P);
    repeat (L) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/db9md_poll_sequencer.md
# db9md_poll_sequencer

Sequencer for the shared Serial SNAC DB9 Mega Drive pad interface. It drives the `joy_split` port-select and `joy_mdsel` pad-select lines that are common to both DB9 ports, and samples the six shared `USER_IN` data lines at the correct phase of each select cycle. It decodes 3-button and 6-button pads and publishes one debounced-by-frame 16-bit button word per player. It sits between the user-port pins and the `joystick_0`/`joystick_1` mux in `emu`.

## Interface

Parameters:
- `PHASE_CYC`, default 480: clocks per select phase (10 µs at 48 MHz); valid range ≥ 4.
- `IDLE_CYC`, default 96000: idle clocks after each P1+P2 pass (2 ms); valid range ≥ 1. Lets the pad's internal 6-button counter expire.

Ports:
- `clk_sys`, input, 1: system clock, 48 MHz.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `enable`, input, 1: polling enable; tied to `|status[31:30]`.
- `joy_in`, input, 6: raw pad lines, active-low. Bit assignment: [0] pin1, [1] pin2, [2] pin3, [3] pin4, [4] pin6, [5] pin9.
- `joy_split`, output, 1: port select; 1 = P1 port, 0 = P2 port.
- `joy_mdsel`, output, 1: Mega Drive SELECT line.
- `joystick1`, output, 16: P1 buttons, active-high.
- `joystick2`, output, 16: P2 buttons, active-high.
- `present1`, `present2`, output, 1: a pad was detected on the port in its last frame.
- `six1`, `six2`, output, 1: the pad on the port was detected as 6-button.
- `upd`, output, 1: one-cycle pulse when both player words have been refreshed.

Button word layout: [0] R, [1] L, [2] D, [3] U, [4] B, [5] C, [6] A, [7] Start, [8] Mode, [9] X, [10] Y, [11] Z, [15:12] always 0.

## Operation

- `joy_in` passes through a 2-FF synchronizer. All samples are taken from the synchronized value and inverted to active-high.
- States are IDLE, P1 and P2, each with phase counter `ph` (0–7) and cycle counter `cnt` (0 to `PHASE_CYC-1`). A sample is taken on the last cycle of a phase (`cnt = PHASE_CYC-1`).
- Sequence: IDLE(`IDLE_CYC`) → P1(8 phases) → P2(8 phases) → IDLE, repeating.
- `joy_split` is 1 in IDLE and P1, and 0 in P2.
- `joy_mdsel` is 1 in IDLE and during even phases, and 0 during odd phases.
- Per-phase decode (U, D, L, R = bits 0–3; pin6 = bit 4; pin9 = bit 5):
  - ph0: U D L R, B = pin6, C = pin9.
  - ph1: A = pin6, Start = pin9. If L and R are both asserted, then present = 1, else present = 0.
  - ph2–ph4: no capture.
  - ph5: if U D L R are all asserted, then six = 1.
  - ph6: if six = 1, Z = U, Y = D, X = L, Mode = R.
  - ph7: no capture.
- Frame commit occurs at the end of ph7:
  - If present = 0, the word is 0x0000 and six = 0.
  - If present = 1 and six = 0, word bits [11:8] are 0.
  - The word, `presentN` and `sixN` update atomically. Scratch registers are cleared at the start of ph0.
- `enable` = 0:
  - The FSM forces IDLE with counters cleared.
  - `joy_split` = 1 and `joy_mdsel` = 1.
  - All outputs are cleared on the next edge.
  - On re-enable, polling restarts with a full IDLE period.

## Timing

- Reset values: `joy_split` = 1, `joy_mdsel` = 1, all joystick, present, six and `upd` outputs = 0, state IDLE with `cnt` = 0. Reset asserted mid-frame returns everything to these values immediately (async) and discards partial samples.
- The first P1 ph0 begins `IDLE_CYC` clocks after `reset_n` rises with `enable` = 1.
- Each phase lasts exactly `PHASE_CYC` clocks. `joy_mdsel` and `joy_split` are registered outputs and toggle on the edge that starts a phase.
- Full pass length: `16*PHASE_CYC + IDLE_CYC` clocks.
- `joystick1` updates on the edge after P1 ph7's last cycle. `joystick2` and the `upd` pulse occur on the edge after P2 ph7's last cycle.
- Input latency: 2 synchronizer clocks, so pin changes later than `PHASE_CYC-3` clocks into a phase are not guaranteed to be captured in that phase.
- The commit and a falling `enable` on the same edge: disable wins, and outputs are cleared.

## Test plan

- **Reset:** hold `reset_n` = 0 mid-P2, with `PHASE_CYC` = 8 and `IDLE_CYC` = 32 → pins read 1/1, words = 0, `upd` = 0. Release → the first `joy_mdsel` falling edge comes exactly 32 + 8 clocks later, and `joy_mdsel` then toggles every 8 clocks.
- **No pad:** `joy_in` = 6'h3F → `present1` = `present2` = 0, both words 0x0000, and `upd` pulses once per 160-clock pass.
- **3-button P1:** a bus-functional pad model (responds to `joy_mdsel` and `joy_split`) holds A + Right → `joystick1` = 0x0041, `six1` = 0, `present1` = 1. `joystick2` stays 0x0000 (P2 port unplugged).
- **6-button P2:** pad holds Up + Mode + Z → `joystick2` = 0x0908, `six2` = 1. Releasing Z → the next commit gives 0x0108.
- **Disable:** drop `enable` during P1 ph3 → within 1 clock `joy_mdsel` = 1 and `joy_split` = 1, and the next edge clears all outputs. Re-enable → P1 ph0 starts after a full `IDLE_CYC`.
- **Late pin change:** assert B 1 clock before the end of ph0 → not reported in that frame; reported as 0x0010 in the next frame.
